// File: rtl/reaction_ctrl_pkg.sv
// Shared definitions for the reaction tester: state encoding, LFSR constants
// and the default millisecond prescale for a 125 MHz clock.
package reaction_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEFAULT_TICKS_PER_MS = 125000;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICKS_PER_MS clocks, restartable
// via clr so the first tick lands exactly TICKS_PER_MS cycles after a clear.
module ms_tick_gen
  import reaction_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clr || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-tester trial sequencer: random foreperiod, GO stimulus, then a
// millisecond reaction count with false-start and timeout detection.
module reaction_ctrl
  import reaction_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = DEFAULT_TICKS_PER_MS,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned MAX_MS       = 9999,
  parameter int unsigned RT_W         = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_btn,
  input  logic            react_btn,
  output logic            led_go,
  output logic            busy,
  output logic [RT_W-1:0] result_ms,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout,
  output logic [2:0]      state_o
);

  localparam int unsigned DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam logic [DLY_W-1:0] MIN_DLY = DLY_W'(MIN_DELAY_MS);
  localparam logic [RT_W-1:0]  RT_MAX  = RT_W'(MAX_MS);
  localparam logic [RT_W-1:0]  RT_LAST = RT_W'(MAX_MS - 1);

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DLY_W-1:0] delayCnt_q, delayCnt_d;
  logic [RT_W-1:0]  rtCnt_q, rtCnt_d;
  logic [RT_W-1:0]  resultMs_q, resultMs_d;
  logic             resultValid_q, resultValid_d;
  logic             falseStart_q, falseStart_d;
  logic             timeout_q, timeout_d;
  logic             startHist_q, reactHist_q;
  logic             startRise, reactRise;
  logic             tick, tickClr;

  assign startRise = start_btn & ~startHist_q;
  assign reactRise = react_btn & ~reactHist_q;

  ms_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tickClr),
    .tick (tick)
  );

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsrNext(lfsr_q);
    delayCnt_d    = delayCnt_q;
    rtCnt_d       = rtCnt_q;
    resultMs_d    = resultMs_q;
    resultValid_d = resultValid_q;
    falseStart_d  = falseStart_q;
    timeout_d     = timeout_q;
    tickClr       = 1'b0;

    unique case (state_q)
      // A finished or fouled trial can be restarted directly, just like idle.
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (startRise) begin
          state_d       = ST_WAIT;
          delayCnt_d    = MIN_DLY + DLY_W'(lfsr_q[RAND_BITS-1:0]);
          resultValid_d = 1'b0;
          falseStart_d  = 1'b0;
          timeout_d     = 1'b0;
          tickClr       = 1'b1;
        end
      end

      ST_WAIT: begin
        if (reactRise) begin
          state_d      = ST_FOUL;
          falseStart_d = 1'b1;
        end else if (tick) begin
          if (delayCnt_q == DLY_W'(1)) begin
            state_d = ST_GO;
            rtCnt_d = '0;
            tickClr = 1'b1;
          end else begin
            delayCnt_d = delayCnt_q - DLY_W'(1);
          end
        end
      end

      // The press is credited with the count before any coincident tick.
      ST_GO: begin
        if (reactRise) begin
          state_d       = ST_DONE;
          resultMs_d    = rtCnt_q;
          resultValid_d = 1'b1;
        end else if (tick) begin
          if (rtCnt_q == RT_LAST) begin
            state_d       = ST_DONE;
            resultMs_d    = RT_MAX;
            resultValid_d = 1'b1;
            timeout_d     = 1'b1;
          end else begin
            rtCnt_d = rtCnt_q + RT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // History registers reset high so a button already held at reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_SEED;
      delayCnt_q    <= '0;
      rtCnt_q       <= '0;
      resultMs_q    <= '0;
      resultValid_q <= 1'b0;
      falseStart_q  <= 1'b0;
      timeout_q     <= 1'b0;
      startHist_q   <= 1'b1;
      reactHist_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      delayCnt_q    <= delayCnt_d;
      rtCnt_q       <= rtCnt_d;
      resultMs_q    <= resultMs_d;
      resultValid_q <= resultValid_d;
      falseStart_q  <= falseStart_d;
      timeout_q     <= timeout_d;
      startHist_q   <= start_btn;
      reactHist_q   <= react_btn;
    end
  end

  assign led_go       = (state_q == ST_GO);
  assign busy         = (state_q == ST_WAIT) || (state_q == ST_GO);
  assign state_o      = state_q;
  assign result_ms    = resultMs_q;
  assign result_valid = resultValid_q;
  assign false_start  = falseStart_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a 4-cycle millisecond, 3-4 ms
// foreperiod and a 20 ms ceiling; the foreperiod is predicted from an LFSR copy.
module tb_reaction_ctrl;

  localparam int unsigned TPM    = 4;
  localparam int unsigned MIN_MS = 3;
  localparam int unsigned RB     = 1;
  localparam int unsigned MAXMS  = 20;
  localparam int unsigned RTW    = 14;

  logic           clk;
  logic           rst_n;
  logic           start_btn;
  logic           react_btn;
  logic           led_go;
  logic           busy;
  logic [RTW-1:0] result_ms;
  logic           result_valid;
  logic           false_start;
  logic           timeout;
  logic [2:0]     state_o;

  int vectors;
  int miscompares;
  logic [15:0] lfsrModel;

  reaction_ctrl #(
    .TICKS_PER_MS(TPM),
    .MIN_DELAY_MS(MIN_MS),
    .RAND_BITS   (RB),
    .MAX_MS      (MAXMS),
    .RT_W        (RTW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .led_go      (led_go),
    .busy        (busy),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .false_start (false_start),
    .timeout     (timeout),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ 16'hB400;
    return nxt;
  endfunction

  // Reference copy of the design's free-running LFSR.
  always @(posedge clk) begin
    if (!rst_n) lfsrModel <= 16'hACE1;
    else        lfsrModel <= lfsrStep(lfsrModel);
  end

  task automatic stepClock(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startLvl, input logic reactLvl);
    start_btn = startLvl;
    react_btn = reactLvl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Press start, then wait (bounded) for GO and check the foreperiod length.
  task automatic runToGo(input string tag);
    int expDelay;
    int cycles;
    expDelay = int'(MIN_MS) + int'(lfsrModel[0]);
    applyStimulus(1'b1, 1'b0);
    stepClock(1);
    cycles = 1;
    applyStimulus(1'b0, 1'b0);
    checkOutput({tag, "_enterWait"}, 32'(state_o), 32'd1);
    while (led_go !== 1'b1 && cycles < 200) begin
      stepClock(1);
      cycles++;
    end
    checkOutput({tag, "_goReached"}, 32'(led_go), 32'd1);
    checkOutput({tag, "_foreperiod"}, 32'(cycles), 32'(1 + int'(TPM) * expDelay));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b1, 1'b0);
    stepClock(3);
    checkOutput("rstState", 32'(state_o), 32'd0);
    checkOutput("rstLedGo", 32'(led_go), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstResult", 32'(result_ms), 32'd0);
    checkOutput("rstValid", 32'(result_valid), 32'd0);
    checkOutput("rstFalseStart", 32'(false_start), 32'd0);
    checkOutput("rstTimeout", 32'(timeout), 32'd0);

    rst_n = 1'b1;
    stepClock(5);
    checkOutput("startHeldThroughReset", 32'(state_o), 32'd0);
    applyStimulus(1'b0, 1'b0);
    stepClock(2);
    checkOutput("stillIdle", 32'(state_o), 32'd0);

    runToGo("trialA");
    checkOutput("trialA_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0);
    stepClock(2);
    checkOutput("startInGoIgnored", 32'(state_o), 32'd2);
    applyStimulus(1'b0, 1'b0);
    stepClock(6);
    applyStimulus(1'b0, 1'b1);
    stepClock(1);
    checkOutput("trialA_valid", 32'(result_valid), 32'd1);
    checkOutput("trialA_result", 32'(result_ms), 32'd2);
    checkOutput("trialA_timeout", 32'(timeout), 32'd0);
    checkOutput("trialA_state", 32'(state_o), 32'd3);
    checkOutput("trialA_ledOff", 32'(led_go), 32'd0);
    applyStimulus(1'b0, 1'b0);
    stepClock(1);
    applyStimulus(1'b0, 1'b1);
    stepClock(2);
    checkOutput("reactInDoneIgnored", 32'(state_o), 32'd3);
    checkOutput("resultHeld", 32'(result_ms), 32'd2);
    applyStimulus(1'b0, 1'b0);
    stepClock(1);

    applyStimulus(1'b1, 1'b0);
    stepClock(1);
    checkOutput("restartFromDone", 32'(state_o), 32'd1);
    checkOutput("restartClearsValid", 32'(result_valid), 32'd0);
    checkOutput("restartBusy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0);
    stepClock(2);
    applyStimulus(1'b0, 1'b1);
    stepClock(1);
    checkOutput("foulState", 32'(state_o), 32'd4);
    checkOutput("foulFlag", 32'(false_start), 32'd1);
    checkOutput("foulValid", 32'(result_valid), 32'd0);
    checkOutput("foulLedGo", 32'(led_go), 32'd0);
    checkOutput("foulBusy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0);
    stepClock(1);

    runToGo("trialC");
    checkOutput("trialC_foulCleared", 32'(false_start), 32'd0);
    stepClock(79);
    checkOutput("trialC_stillGo", 32'(state_o), 32'd2);
    stepClock(1);
    checkOutput("timeoutState", 32'(state_o), 32'd3);
    checkOutput("timeoutResult", 32'(result_ms), 32'(MAXMS));
    checkOutput("timeoutFlag", 32'(timeout), 32'd1);
    checkOutput("timeoutValid", 32'(result_valid), 32'd1);
    checkOutput("timeoutLedOff", 32'(led_go), 32'd0);

    runToGo("trialD");
    checkOutput("trialD_timeoutCleared", 32'(timeout), 32'd0);
    stepClock(23);
    applyStimulus(1'b0, 1'b1);
    stepClock(1);
    checkOutput("coincidentResult", 32'(result_ms), 32'd5);
    checkOutput("coincidentValid", 32'(result_valid), 32'd1);
    checkOutput("coincidentTimeout", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b0);
    stepClock(1);

    runToGo("trialE");
    stepClock(5);
    rst_n = 1'b0;
    stepClock(1);
    checkOutput("midGoRstState", 32'(state_o), 32'd0);
    checkOutput("midGoRstLedGo", 32'(led_go), 32'd0);
    checkOutput("midGoRstBusy", 32'(busy), 32'd0);
    checkOutput("midGoRstValid", 32'(result_valid), 32'd0);
    checkOutput("midGoRstResult", 32'(result_ms), 32'd0);
    rst_n = 1'b1;
    stepClock(3);

    runToGo("trialF");
    stepClock(12);
    applyStimulus(1'b0, 1'b1);
    stepClock(1);
    checkOutput("trialF_result", 32'(result_ms), 32'd3);
    checkOutput("trialF_valid", 32'(result_valid), 32'd1);
    applyStimulus(1'b0, 1'b0);
    stepClock(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
